// File: rtl/program_mem_arbiter_if.sv
// Bus bundle between the program-memory arbiter, its fetch/refill consumers
// and the shared program-memory read port.
//   slave  : the arbiter's view (consumes requests, drives memory request)
//   master : the environment's view (consumers plus program memory)
interface program_mem_arbiter_if #(
    parameter int NUM_CONSUMERS             = 4,
    parameter int PROGRAM_MEM_ADDR_BITS     = 8,
    parameter int PROGRAM_MEM_DATA_BITS     = 16,
    parameter int PROGRAM_MEM_DATA_READ_NUM = 4
);
    localparam int LINE_BITS = PROGRAM_MEM_DATA_READ_NUM * PROGRAM_MEM_DATA_BITS;

    logic [NUM_CONSUMERS-1:0]                       consumer_read_valid;
    logic [NUM_CONSUMERS*PROGRAM_MEM_ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                       consumer_read_ready;
    logic [NUM_CONSUMERS*LINE_BITS-1:0]             consumer_read_data;
    logic                                           mem_read_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]               mem_read_address;
    logic                                           mem_read_ready;
    logic [LINE_BITS-1:0]                           mem_read_data;

    modport slave (
        input  consumer_read_valid,
        input  consumer_read_address,
        input  mem_read_ready,
        input  mem_read_data,
        output consumer_read_ready,
        output consumer_read_data,
        output mem_read_valid,
        output mem_read_address
    );

    modport master (
        output consumer_read_valid,
        output consumer_read_address,
        output mem_read_ready,
        output mem_read_data,
        input  consumer_read_ready,
        input  consumer_read_data,
        input  mem_read_valid,
        input  mem_read_address
    );
endinterface

// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing one program-memory read port between several
// instruction fetchers / icache refill engines. One line read is in flight at
// a time; the winner keeps its ready/data until it drops its request, and the
// next arbitration starts from the consumer after the last one served.
module program_mem_arbiter #(
    parameter int NUM_CONSUMERS             = 4,
    parameter int PROGRAM_MEM_ADDR_BITS     = 8,
    parameter int PROGRAM_MEM_DATA_BITS     = 16,
    parameter int PROGRAM_MEM_DATA_READ_NUM = 4,
    localparam int GRANT_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    program_mem_arbiter_if.slave    bus,
    output logic [GRANT_BITS-1:0]   grant_id,
    output logic                    busy
);
    localparam int LINE_BITS = PROGRAM_MEM_DATA_READ_NUM * PROGRAM_MEM_DATA_BITS;
    localparam int AW        = PROGRAM_MEM_ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAITING  = 2'd1,
        ST_RELAYING = 2'd2
    } state_t;

    state_t                             state_r, state_s;
    logic [GRANT_BITS-1:0]              grant_id_r, grant_id_s;
    logic [GRANT_BITS-1:0]              last_grant_r, last_grant_s;
    logic                               mem_read_valid_r, mem_read_valid_s;
    logic [AW-1:0]                      mem_read_address_r, mem_read_address_s;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready_r, consumer_read_ready_s;
    logic [NUM_CONSUMERS*LINE_BITS-1:0] consumer_read_data_r, consumer_read_data_s;
    logic                               busy_r;
    logic [GRANT_BITS:0]                pick_s;

    // Round-robin search: first requester strictly after 'last', wrapping.
    // Result MSB flags that somebody was found; low bits hold the index.
    function automatic logic [GRANT_BITS:0] rr_pick(
        input logic [NUM_CONSUMERS-1:0] req,
        input logic [GRANT_BITS-1:0]    last
    );
        logic [GRANT_BITS:0] res;
        int                  idx;
        res = '0;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = NUM_CONSUMERS; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_CONSUMERS;
            if (req[idx]) begin
                res = {1'b1, GRANT_BITS'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        state_s              = state_r;
        grant_id_s           = grant_id_r;
        last_grant_s         = last_grant_r;
        mem_read_valid_s     = mem_read_valid_r;
        mem_read_address_s   = mem_read_address_r;
        consumer_read_ready_s = consumer_read_ready_r;
        consumer_read_data_s = consumer_read_data_r;
        pick_s               = rr_pick(bus.consumer_read_valid, last_grant_r);

        case (state_r)
            ST_IDLE: begin
                if (pick_s[GRANT_BITS]) begin
                    grant_id_s         = pick_s[GRANT_BITS-1:0];
                    mem_read_address_s = bus.consumer_read_address[int'(pick_s[GRANT_BITS-1:0])*AW +: AW];
                    mem_read_valid_s   = 1'b1;
                    state_s            = ST_WAITING;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAITING: begin
                // The request is never aborted, even if the consumer gives up.
                if (bus.mem_read_ready) begin
                    mem_read_valid_s = 1'b0;
                    consumer_read_data_s[int'(grant_id_r)*LINE_BITS +: LINE_BITS] = bus.mem_read_data;
                    consumer_read_ready_s = '0;
                    consumer_read_ready_s[grant_id_r] = 1'b1;
                    state_s = ST_RELAYING;
                end else begin
                    state_s = ST_WAITING;
                end
            end
            ST_RELAYING: begin
                if (!bus.consumer_read_valid[grant_id_r]) begin
                    consumer_read_ready_s = '0;
                    last_grant_s          = grant_id_r;
                    state_s               = ST_IDLE;
                end else begin
                    state_s = ST_RELAYING;
                end
            end
            default: begin
                mem_read_valid_s      = 1'b0;
                consumer_read_ready_s = '0;
                state_s               = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r               <= ST_IDLE;
            grant_id_r            <= '0;
            last_grant_r          <= GRANT_BITS'(NUM_CONSUMERS - 1);
            mem_read_valid_r      <= 1'b0;
            mem_read_address_r    <= '0;
            consumer_read_ready_r <= '0;
            consumer_read_data_r  <= '0;
            busy_r                <= 1'b0;
        end else begin
            state_r               <= state_s;
            grant_id_r            <= grant_id_s;
            last_grant_r          <= last_grant_s;
            mem_read_valid_r      <= mem_read_valid_s;
            mem_read_address_r    <= mem_read_address_s;
            consumer_read_ready_r <= consumer_read_ready_s;
            consumer_read_data_r  <= consumer_read_data_s;
            busy_r                <= (state_s != ST_IDLE);
        end
    end

    assign bus.mem_read_valid      = mem_read_valid_r;
    assign bus.mem_read_address    = mem_read_address_r;
    assign bus.consumer_read_ready = consumer_read_ready_r;
    assign bus.consumer_read_data  = consumer_read_data_r;
    assign grant_id                = grant_id_r;
    assign busy                    = busy_r;
endmodule

// File: tb/tb_program_mem_arbiter.sv
// Bench for program_mem_arbiter: directed scenarios with literal expectations,
// then randomized consumers/memory/reset, all compared every cycle against a
// transaction-level reference model.
module tb_program_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int RN = 4;
    localparam int LW = RN * DW;
    localparam int GW = 2;
    localparam int VW = N * LW;

    logic          clk = 1'b0;
    logic          reset;
    logic [GW-1:0] grant_id;
    logic          busy;

    always #5 clk = ~clk;

    program_mem_arbiter_if #(
        .NUM_CONSUMERS(N), .PROGRAM_MEM_ADDR_BITS(AW),
        .PROGRAM_MEM_DATA_BITS(DW), .PROGRAM_MEM_DATA_READ_NUM(RN)
    ) bus ();

    program_mem_arbiter #(
        .NUM_CONSUMERS(N), .PROGRAM_MEM_ADDR_BITS(AW),
        .PROGRAM_MEM_DATA_BITS(DW), .PROGRAM_MEM_DATA_READ_NUM(RN)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .grant_id(grant_id), .busy(busy)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: one transaction record plus expected outputs
    bit            m_in_flight, m_delivered;
    int            m_grant, m_last;
    logic          exp_mv;
    logic [AW-1:0] exp_ma;
    logic [N-1:0]  exp_crr;
    logic [VW-1:0] exp_crd;
    logic [GW-1:0] exp_gid;
    logic          exp_busy;

    // stimulus agents
    bit            auto_mode;
    bit            mem_fixed_en;
    logic [LW-1:0] mem_fixed;
    int            mem_delay;
    int            mem_cnt;
    int            cst  [N];
    int            hold [N];

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Advance the reference model by one clock using the inputs just sampled.
    task automatic model_step();
        if (reset) begin
            m_in_flight = 1'b0; m_delivered = 1'b0; m_grant = 0; m_last = N - 1;
            exp_mv = 1'b0; exp_ma = '0; exp_crr = '0; exp_crd = '0; exp_gid = '0;
        end else if (!m_in_flight) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (bus.consumer_read_valid[c]) begin
                    m_grant = c; m_in_flight = 1'b1; m_delivered = 1'b0;
                    break;
                end
            end
            if (m_in_flight) begin
                exp_gid = GW'(m_grant);
                exp_ma  = bus.consumer_read_address[m_grant*AW +: AW];
                exp_mv  = 1'b1;
            end
        end else if (!m_delivered) begin
            if (bus.mem_read_ready) begin
                exp_mv = 1'b0;
                exp_crd[m_grant*LW +: LW] = bus.mem_read_data;
                exp_crr = '0;
                exp_crr[m_grant] = 1'b1;
                m_delivered = 1'b1;
            end
        end else begin
            if (!bus.consumer_read_valid[m_grant]) begin
                exp_crr = '0; m_last = m_grant; m_in_flight = 1'b0;
            end
        end
        exp_busy = m_in_flight;
    endtask

    task automatic compare();
        chk("mem_read_valid", bus.mem_read_valid, exp_mv);
        chk("mem_read_address", bus.mem_read_address, exp_ma);
        chk("consumer_read_ready", bus.consumer_read_ready, exp_crr);
        chk("consumer_read_data", bus.consumer_read_data, exp_crd);
        chk("grant_id", grant_id, exp_gid);
        chk("busy", busy, exp_busy);
    endtask

    // Program memory: answers each request after a delay with a 1-cycle ready.
    task automatic mem_agent();
        if (reset) begin
            mem_cnt = -1; bus.mem_read_ready = 1'b0;
        end else if (bus.mem_read_ready) begin
            bus.mem_read_ready = 1'b0; mem_cnt = -1;
        end else begin
            if (bus.mem_read_valid && mem_cnt < 0)
                mem_cnt = auto_mode ? int'($urandom_range(0, 4)) : mem_delay;
            if (mem_cnt == 0) begin
                bus.mem_read_ready = 1'b1; mem_cnt = -1;
            end else if (mem_cnt > 0) begin
                mem_cnt--;
            end
        end
        if (bus.mem_read_ready && mem_fixed_en) bus.mem_read_data = mem_fixed;
        else bus.mem_read_data = {$urandom, $urandom};
    endtask

    // Random consumers: request, sometimes give up or change address, hold after ready.
    task automatic cons_agent();
        for (int i = 0; i < N; i++) begin
            case (cst[i])
                0: if ($urandom_range(0, 3) == 0) begin
                       bus.consumer_read_valid[i] = 1'b1;
                       bus.consumer_read_address[i*AW +: AW] = AW'($urandom);
                       cst[i] = 1;
                   end
                1: if (bus.consumer_read_ready[i]) begin
                       hold[i] = $urandom_range(0, 3);
                       if (hold[i] == 0) begin bus.consumer_read_valid[i] = 1'b0; cst[i] = 0; end
                       else cst[i] = 2;
                   end else if ($urandom_range(0, 39) == 0) begin
                       bus.consumer_read_valid[i] = 1'b0; cst[i] = 0;
                   end else if ($urandom_range(0, 7) == 0) begin
                       bus.consumer_read_address[i*AW +: AW] = AW'($urandom);
                   end
                default: begin
                    hold[i]--;
                    if (hold[i] <= 0) begin bus.consumer_read_valid[i] = 1'b0; cst[i] = 0; end
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        mem_agent();
        if (auto_mode) cons_agent();
    endtask

    task automatic wait_ready(output int who, output int n);
        who = -1; n = 0;
        while (bus.consumer_read_ready == '0 && n < 40) begin tick(); n++; end
        chk("ready_within_budget", (bus.consumer_read_ready != '0), 1'b1);
        for (int i = 0; i < N; i++) if (bus.consumer_read_ready[i]) who = i;
    endtask

    task automatic serve(output int who);
        int n;
        wait_ready(who, n);
        if (who >= 0) bus.consumer_read_valid[who] = 1'b0;
        tick();
    endtask

    initial begin
        int who, n;
        auto_mode = 1'b0; mem_fixed_en = 1'b1; mem_fixed = 64'h0004_0003_0002_0001;
        mem_delay = 2; mem_cnt = -1;
        for (int i = 0; i < N; i++) begin cst[i] = 0; hold[i] = 0; end
        bus.consumer_read_valid = '0; bus.consumer_read_address = '0;
        bus.mem_read_ready = 1'b0; bus.mem_read_data = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_grant", grant_id, 2'd0);
        chk("reset_ready", bus.consumer_read_ready, 4'b0000);
        chk("reset_mem_valid", bus.mem_read_valid, 1'b0);

        // single request from consumer 2, memory answers 3 cycles later
        bus.consumer_read_valid[2] = 1'b1;
        bus.consumer_read_address[2*AW +: AW] = 8'h14;
        tick();
        chk("single_addr", bus.mem_read_address, 8'h14);
        chk("single_mem_valid", bus.mem_read_valid, 1'b1);
        chk("single_grant", grant_id, 2'd2);
        wait_ready(who, n);
        chk("single_latency", n, 3);
        chk("single_ready", bus.consumer_read_ready, 4'b0100);
        chk("single_data", bus.consumer_read_data[2*LW +: LW], 64'h0004_0003_0002_0001);

        // consumer keeps valid for 5 more cycles
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("hold_ready", bus.consumer_read_ready, 4'b0100);
            chk("hold_mem_valid", bus.mem_read_valid, 1'b0);
            chk("hold_busy", busy, 1'b1);
        end
        bus.consumer_read_valid[2] = 1'b0;
        tick();
        chk("release_ready", bus.consumer_read_ready, 4'b0000);
        chk("release_busy", busy, 1'b0);

        // all four request at once after reset
        reset = 1'b1; tick(); reset = 1'b0;
        mem_delay = 1;
        bus.consumer_read_address = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.consumer_read_valid = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            serve(who);
            chk("all_order", who, s);
        end

        // wrap-around: last served is 3, requests on 1 and 3
        bus.consumer_read_valid = 4'b1010;
        serve(who); chk("wrap_first", who, 1);
        serve(who); chk("wrap_second", who, 3);

        // fairness: 0 re-requests right away, 3 keeps requesting
        bus.consumer_read_valid = 4'b1001;
        for (int s = 0; s < 4; s++) begin
            wait_ready(who, n);
            chk("fair_alternate", who, (s % 2 == 0) ? 0 : 3);
            if (who >= 0) begin
                bus.consumer_read_valid[who] = 1'b0;
                tick();
                bus.consumer_read_valid[who] = 1'b1;
            end
        end
        bus.consumer_read_valid = '0;
        tick(); tick(); tick();

        // reset while waiting on memory, then a clean request
        mem_delay = 4; mem_fixed = 64'hBEEF_CAFE_1234_5678;
        bus.consumer_read_address[0 +: AW] = 8'h3C;
        bus.consumer_read_valid[0] = 1'b1;
        tick(); tick();
        chk("midrst_busy_before", busy, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_mem_valid", bus.mem_read_valid, 1'b0);
        chk("midrst_addr", bus.mem_read_address, 8'h00);
        chk("midrst_ready", bus.consumer_read_ready, 4'b0000);
        chk("midrst_data", bus.consumer_read_data, 256'h0);
        chk("midrst_grant", grant_id, 2'd0);
        chk("midrst_busy", busy, 1'b0);
        wait_ready(who, n);
        chk("midrst_who", who, 0);
        chk("midrst_line", bus.consumer_read_data[0 +: LW], 64'hBEEF_CAFE_1234_5678);
        chk("midrst_addr_kept", bus.mem_read_address, 8'h3C);
        bus.consumer_read_valid[0] = 1'b0;
        tick();

        // randomized traffic with occasional resets
        auto_mode = 1'b1; mem_fixed_en = 1'b0;
        bus.consumer_read_valid = '0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/program_mem_arbiter.md
PROGRAM_MEM_ARBITER -- requirements
Module: program_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4, number of fetcher/icache refill requesters sharing one program-memory port.
REQ-002 SHALL have parameter PROGRAM_MEM_ADDR_BITS, default 8, program memory address width.
REQ-003 SHALL have parameter PROGRAM_MEM_DATA_BITS, default 16, width of one instruction word.
REQ-004 SHALL have parameter PROGRAM_MEM_DATA_READ_NUM, default 4, number of instruction words returned per read (one cache line).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port consumer_read_valid  input  NUM_CONSUMERS  per-consumer read request, held high until its ready is seen.
REQ-008 SHALL have port consumer_read_address  input  NUM_CONSUMERS*PROGRAM_MEM_ADDR_BITS  packed addresses; consumer i occupies slice i.
REQ-009 SHALL have port consumer_read_ready  output  NUM_CONSUMERS  per-consumer completion flag.
REQ-010 SHALL have port consumer_read_data  output  NUM_CONSUMERS*PROGRAM_MEM_DATA_READ_NUM*PROGRAM_MEM_DATA_BITS  packed line data; consumer i occupies slice i.
REQ-011 SHALL have port mem_read_valid  output  1  request to program memory.
REQ-012 SHALL have port mem_read_address  output  PROGRAM_MEM_ADDR_BITS  address to program memory.
REQ-013 SHALL have port mem_read_ready  input  1  program memory completion, one or more cycles.
REQ-014 SHALL have port mem_read_data  input  PROGRAM_MEM_DATA_READ_NUM*PROGRAM_MEM_DATA_BITS  line data, valid while mem_read_ready is high.
REQ-015 SHALL have port grant_id  output  clog2(NUM_CONSUMERS) (min 1)  index of the consumer currently being served.
REQ-016 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, WAITING, RELAYING; all outputs registered.
REQ-018 In IDLE with any consumer_read_valid high, SHALL grant the first requesting consumer searching from (last_grant+1) mod NUM_CONSUMERS upward with wrap-around.
REQ-019 On grant SHALL, in the same edge, latch grant_id, drive mem_read_address from the granted slice, set mem_read_valid=1 and enter WAITING; mem_read_valid rises exactly 1 cycle after the sampled request.
REQ-020 In WAITING SHALL hold mem_read_valid and mem_read_address stable until mem_read_ready is sampled high.
REQ-021 On mem_read_ready in WAITING SHALL, in one edge, clear mem_read_valid, copy mem_read_data into the granted consumer_read_data slice, set consumer_read_ready[grant_id]=1 and enter RELAYING.
REQ-022 In RELAYING SHALL hold ready and data until consumer_read_valid[grant_id] is sampled low, then clear consumer_read_ready[grant_id], update last_grant=grant_id and return to IDLE.
REQ-023 SHALL never assert more than one consumer_read_ready bit at a time, and never start a new memory request before the previous consumer has dropped valid.
REQ-024 SHALL ignore changes in non-granted valid/address inputs while busy; they are arbitrated on the next IDLE.
REQ-025 SHALL leave non-granted consumer_read_data slices unchanged (last delivered line persists).
REQ-026 A consumer that drops valid while in WAITING SHALL still receive its ready pulse; the arbiter SHALL NOT abort a memory transaction.
REQ-027 Minimum request-to-request turnaround SHALL be 1 IDLE cycle between RELAYING exit and the next mem_read_valid assertion.

Reset
REQ-028 On reset SHALL enter IDLE; mem_read_valid=0, mem_read_address=0, consumer_read_ready=0, consumer_read_data=0, grant_id=0, busy=0, last_grant=NUM_CONSUMERS-1 (so consumer 0 has first priority).
REQ-029 Reset asserted mid-transaction SHALL abandon it in one cycle with the values of REQ-028, independent of mem_read_ready.

Verification
REQ-030 Single request: consumer 2 valid, address 0x14; memory ready 3 cycles later with 0x0004_0003_0002_0001 -> mem_read_address=0x14 one cycle after valid, consumer_read_ready[2] one cycle after mem ready with that data, cleared one cycle after valid drops.
REQ-031 Simultaneous requests from all 4 consumers after reset -> service order 0,1,2,3, each with its own address, no overlapping ready bits.
REQ-032 Fairness: consumer 0 re-requests immediately after each completion while consumer 3 requests continuously -> grants alternate 0,3,0,3.
REQ-033 Wrap-around: last_grant=3, requests on 1 and 3 -> consumer 1 granted first.
REQ-034 Consumer holds valid 5 cycles after ready -> consumer_read_ready stays high 5 cycles, mem_read_valid stays 0, busy stays 1.
REQ-035 Reset pulsed in WAITING -> next cycle all outputs at REQ-028 values; a fresh request to consumer 0 then completes normally.
